// File: rtl/rgb_led_sched_if.sv
// Request/grant bundle between the LED requesters and rgb_led_sched.
// The master side drives requests and play parameters; the slave side drives LED pins.
interface rgb_led_sched_if #(
    parameter int DUR_W = 16
);
    logic [2:0]       req;
    logic [2:0]       color0;
    logic [2:0]       color1;
    logic [2:0]       color2;
    logic [DUR_W-1:0] dur0;
    logic [DUR_W-1:0] dur1;
    logic [DUR_W-1:0] dur2;
    logic [7:0]       half0;
    logic [7:0]       half1;
    logic [7:0]       half2;
    logic [2:0]       grant;
    logic [2:0]       done;
    logic             busy;
    logic             r;
    logic             g;
    logic             b;

    modport master (
        output req,
        output color0, color1, color2,
        output dur0, dur1, dur2,
        output half0, half1, half2,
        input  grant, done, busy,
        input  r, g, b
    );

    modport slave (
        input  req,
        input  color0, color1, color2,
        input  dur0, dur1, dur2,
        input  half0, half1, half2,
        output grant, done, busy,
        output r, g, b
    );
endinterface

// File: rtl/rgb_led_sched.sv
// Three-way priority scheduler for the shared active-low RGB LED.
// Optional feature: define RGB_SCHED_PREEMPT_EN to let higher priority abort a play.
module rgb_led_sched #(
    parameter int TICK_DIV = 12000,
    parameter int DUR_W    = 16
) (
    input logic            clk,
    input logic            rst,
    rgb_led_sched_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_PLAY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       col_q, col_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [7:0]       half_q, half_d;
    logic [DUR_W-1:0] remain_q, remain_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic [7:0]       phase_q, phase_d;
    logic             lit_q, lit_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic [2:0]       led_q, led_d;

    logic [2:0]       pick;
    logic [1:0]       pick_idx;
    logic [2:0]       pick_col;
    logic [DUR_W-1:0] pick_dur;
    logic [7:0]       pick_half;
    logic             tick;
    logic             preempt;
    logic             take;

    // lowest set index wins; pick is one-hot so the decoder below is unique
    assign pick[0] = bus.req[0];
    assign pick[1] = bus.req[1] & ~bus.req[0];
    assign pick[2] = bus.req[2] & ~(|bus.req[1:0]);

    always_comb begin
        pick_idx  = 2'd0;
        pick_col  = bus.color0;
        pick_dur  = bus.dur0;
        pick_half = bus.half0;
        unique case (1'b1)
            pick[1]: begin
                pick_idx  = 2'd1;
                pick_col  = bus.color1;
                pick_dur  = bus.dur1;
                pick_half = bus.half1;
            end
            pick[2]: begin
                pick_idx  = 2'd2;
                pick_col  = bus.color2;
                pick_dur  = bus.dur2;
                pick_half = bus.half2;
            end
            default: ;
        endcase
    end

    assign tick = (state_q == S_PLAY) && (psc_q == PSC_MAX);

`ifdef RGB_SCHED_PREEMPT_EN
    assign preempt = (state_q == S_PLAY) && (|bus.req) && (pick_idx < idx_q);
`else
    assign preempt = 1'b0;
`endif

    assign take = ((state_q == S_IDLE) && (|bus.req)) || preempt;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        col_d    = col_q;
        dur_d    = dur_q;
        half_d   = half_q;
        remain_d = remain_q;
        psc_d    = psc_q;
        phase_d  = phase_q;
        lit_d    = lit_q;
        grant_d  = 3'b000;
        done_d   = 3'b000;

        if (take) begin
            idx_d   = pick_idx;
            col_d   = pick_col;
            dur_d   = pick_dur;
            half_d  = pick_half;
            grant_d = pick;
            state_d = S_GRANT;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_GRANT: begin
                    psc_d    = '0;
                    phase_d  = '0;
                    lit_d    = 1'b1;
                    remain_d = (dur_q == '0) ? DUR_W'(1) : dur_q;
                    state_d  = S_PLAY;
                end
                S_PLAY: begin
                    if (tick) begin
                        psc_d    = '0;
                        remain_d = remain_q - 1'b1;
                        if (half_q != 8'd0) begin
                            if (phase_q == half_q - 8'd1) begin
                                phase_d = '0;
                                lit_d   = ~lit_q;
                            end else begin
                                phase_d = phase_q + 8'd1;
                            end
                        end
                        if (remain_q == DUR_W'(1)) begin
                            done_d  = 3'b001 << idx_q;
                            state_d = S_DONE;
                        end
                    end else begin
                        psc_d = psc_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // LED and busy are registered from the next state so they line up with it
        busy_d = (state_d != S_IDLE);
        led_d  = 3'b111;
        if (state_d == S_PLAY) begin
            led_d = ~(col_d & {3{lit_d}});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            col_q    <= '0;
            dur_q    <= '0;
            half_q   <= '0;
            remain_q <= '0;
            psc_q    <= '0;
            phase_q  <= '0;
            lit_q    <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            led_q    <= 3'b111;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            col_q    <= col_d;
            dur_q    <= dur_d;
            half_q   <= half_d;
            remain_q <= remain_d;
            psc_q    <= psc_d;
            phase_q  <= phase_d;
            lit_q    <= lit_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.r     = led_q[0];
    assign bus.g     = led_q[1];
    assign bus.b     = led_q[2];
endmodule

// File: tb/tb_rgb_led_sched.sv
// Bench for rgb_led_sched: table vectors, random plays against a timeline model,
// plus reset-abort and preemption sequences.
module tb_rgb_led_sched;
    localparam int T  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rgb_led_sched_if #(.DUR_W(DW)) bus ();

    rgb_led_sched #(.TICK_DIV(T), .DUR_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    logic [2:0] cols [3];
    int         durs [3];
    int         halfs[3];

    typedef struct {
        logic [2:0] req;
        logic [2:0] col;
        int         dur;
        int         half;
        int         first;
        int         cycles;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_len(input int d);
        return ((d == 0) ? 1 : d) * T;
    endfunction

    // LED pins for play cycle n: on for h*T cycles, off for h*T, ...
    function automatic logic [2:0] exp_led(input logic [2:0] c, input int h, input int n);
        logic lit;
        if (h == 0) lit = 1'b1;
        else lit = (((n / (h * T)) % 2) == 0);
        return ~(c & {3{lit}});
    endfunction

    task automatic apply_params();
        bus.color0 = cols[0];
        bus.color1 = cols[1];
        bus.color2 = cols[2];
        bus.dur0   = 16'(durs[0]);
        bus.dur1   = 16'(durs[1]);
        bus.dur2   = 16'(durs[2]);
        bus.half0  = 8'(halfs[0]);
        bus.half1  = 8'(halfs[1]);
        bus.half2  = 8'(halfs[2]);
    endtask

    task automatic wait_grant(output int w);
        w = 0;
        @(negedge clk);
        w = 1;
        while (bus.grant == 3'b000 && w < 20) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic serve(input int idx, input int exp_cycles, output int w);
        int n;
        logic [2:0] c;
        int h;
        c = cols[idx];
        h = halfs[idx];
        wait_grant(w);
        chk("grant", bus.grant, 1 << idx);
        chk("busy_in_grant", bus.busy, 1);
        bus.req[idx] = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.done == 3'b000 && n < 400) begin
            chk("led", {bus.b, bus.g, bus.r}, exp_led(c, h, n));
            n++;
            @(negedge clk);
        end
        chk("play_len", n, exp_cycles);
        chk("done", bus.done, 1 << idx);
        chk("led_off_at_done", {bus.b, bus.g, bus.r}, 7);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int seen;
        int n;
        bit first;

        vt[0] = '{req: 3'b001, col: 3'b001, dur: 3, half: 0, first: 0, cycles: 12};
        vt[1] = '{req: 3'b110, col: 3'b010, dur: 2, half: 0, first: 1, cycles: 8};
        vt[2] = '{req: 3'b001, col: 3'b111, dur: 4, half: 1, first: 0, cycles: 16};
        vt[3] = '{req: 3'b100, col: 3'b111, dur: 0, half: 1, first: 2, cycles: 4};
        vt[4] = '{req: 3'b010, col: 3'b000, dur: 2, half: 2, first: 1, cycles: 8};
        vt[5] = '{req: 3'b111, col: 3'b101, dur: 1, half: 0, first: 0, cycles: 4};

        bus.req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cols[k]  = 3'b000;
            durs[k]  = 1;
            halfs[k] = 0;
        end
        apply_params();

        @(negedge clk);
        @(negedge clk);
        chk("reset_grant", bus.grant, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_led", {bus.b, bus.g, bus.r}, 7);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) begin
                cols[k]  = vt[i].col;
                durs[k]  = vt[i].dur;
                halfs[k] = vt[i].half;
            end
            apply_params();
            bus.req = vt[i].req;
            serve(vt[i].first, vt[i].cycles, w);
            for (int j = 0; j < 3; j++) begin
                if (vt[i].req[j] && j != vt[i].first) begin
                    serve(j, model_len(durs[j]), w);
                    chk("gap_after_done", w, 2);
                end
            end
        end

        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 3; k++) begin
                cols[k]  = 3'($urandom_range(0, 7));
                durs[k]  = int'($urandom_range(0, 4));
                halfs[k] = int'($urandom_range(0, 3));
            end
            apply_params();
            bus.req = 3'($urandom_range(1, 7));
            first = 1'b1;
            for (int j = 0; j < 3; j++) begin
                if (bus.req[j]) begin
                    serve(j, model_len(durs[j]), w);
                    if (!first) chk("rand_gap", w, 2);
                    first = 1'b0;
                end
            end
        end

        // asynchronous reset in the middle of a play
        cols[2]  = 3'b111;
        durs[2]  = 10;
        halfs[2] = 0;
        apply_params();
        bus.req = 3'b100;
        wait_grant(w);
        chk("abort_grant", bus.grant, 4);
        bus.req[2] = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_led", {bus.b, bus.g, bus.r}, 7);
        chk("abort_busy", bus.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done != 3'b000) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        chk("idle_after_abort", bus.busy, 0);
        cols[1]  = 3'b010;
        durs[1]  = 2;
        halfs[1] = 1;
        apply_params();
        bus.req = 3'b010;
        serve(1, 8, w);
        chk("grant_after_reset", w, 1);

        // higher priority request three ticks into a long play
        cols[2]  = 3'b100;
        durs[2]  = 10;
        halfs[2] = 0;
        cols[0]  = 3'b011;
        durs[0]  = 1;
        halfs[0] = 0;
        apply_params();
        bus.req = 3'b100;
        wait_grant(w);
        chk("pre_grant", bus.grant, 4);
        bus.req[2] = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            chk("pre_led", {bus.b, bus.g, bus.r}, 3'b011);
            n++;
        end
        bus.req[0] = 1'b1;
`ifdef RGB_SCHED_PREEMPT_EN
        serve(0, 4, w);
        chk("preempt_latency", w, 1);
`else
        @(negedge clk);
        while (bus.done == 3'b000 && n < 400) begin
            chk("nopre_led", {bus.b, bus.g, bus.r}, 3'b011);
            n++;
            @(negedge clk);
        end
        chk("nopre_len", n, 40);
        chk("nopre_done", bus.done, 4);
        serve(0, 4, w);
        chk("nopre_gap", w, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/rgb_led_sched.md
# rgb_led_sched

Priority scheduler that shares the board's single active-low RGB LED among three requesters (0 = highest priority). Each requester submits a color, an on-duration and an optional blink half-period. The block grants one request at a time, plays it for exactly the requested number of ticks and then signals completion. It sits between the status/error/heartbeat sources and the r/g/b LED pins, and supersedes free-running color stepping.

## Interface
- `TICK_DIV`, default 12000: clk cycles per tick (1 ms at 12 MHz).
- `DUR_W`, default 16: width of the duration fields, in ticks.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in 3: request, one bit per requester; level, held until granted.
- `color0`, `color1`, `color2` in 3 each: {b,g,r} active-high color for requester i; sampled at grant.
- `dur0`, `dur1`, `dur2` in DUR_W each: play length in ticks; 0 is treated as 1.
- `half0`, `half1`, `half2` in 8 each: blink half-period in ticks; 0 means steady on.
- `grant` out 3: one-cycle one-hot pulse; the request is accepted and its parameters are latched.
- `done` out 3: one-cycle one-hot pulse when a play finishes normally.
- `busy` out 1: high in GRANT, PLAY and DONE.
- `r`, `g`, `b` out 1 each: LED pins, active-low.

## Operation
- FSM states: IDLE, GRANT, PLAY, DONE.
- IDLE: if `req != 0`, select the lowest set index i, latch color/dur/half of i, and go to GRANT. LED is off (r=g=b=1).
- GRANT (1 cycle): `grant[i]=1`. Clear the prescaler, phase counter and lit flag. Load `remain <= (dur==0) ? 1 : dur`, `lit <= 1`. Go to PLAY.
- PLAY: the prescaler counts 0..TICK_DIV-1 and pulses `tick` on TICK_DIV-1.
  - On each tick, decrement `remain`. When `tick && remain==1`, go to DONE.
  - Blink: if half != 0, the phase counter increments on tick. When it reaches half-1 on a tick, it clears and `lit` toggles. If half == 0, `lit` stays 1.
- DONE (1 cycle): `done[i]=1`, LED off. Go to IDLE.
- The requester must drop `req[i]` on the cycle after `grant[i]`. A `req[i]` still high in IDLE is a new request.
- Requests arriving during GRANT/PLAY/DONE wait; there is no queue beyond the level on `req`.
- LED outputs are registered: `r = ~(lit & col[0])`, `g = ~(lit & col[1])`, `b = ~(lit & col[2])` in PLAY; all 1 otherwise.
- Color 3'b000 plays dark for the full duration and still completes with `done`.
- Reset, at any time including mid-PLAY: state IDLE, grant=0, done=0, busy=0, r=g=b=1, all counters 0. No `done` is issued for an aborted play.

## Timing
- `req[i]` high in IDLE at cycle N: `grant[i]` and `busy` are high at N+1, and the LED shows the color from N+2.
- PLAY lasts exactly dur×TICK_DIV cycles (dur ≥ 1). `done` is high on the next cycle, with the LED off.
- A new grant occurs at the earliest 2 cycles after `done`.
- Blink with half=h: the LED is on for h×TICK_DIV cycles, then off for h×TICK_DIV cycles, and so on, starting on. It is truncated by duration expiry.
- Simultaneous requests in IDLE: the lowest index wins; the others stay pending.

## Configuration
- `RGB_SCHED_PREEMPT_EN` defined:
  - In PLAY, if `req[j]` is set with j < the current index, abort the current play and go to GRANT for j at the next cycle.
  - The preempted requester gets neither `done` nor a retry.
  - Equal or lower priority requests never preempt.
- Macro undefined: a granted play always runs to completion; priority applies only in IDLE.

## Test plan
- TICK_DIV=4, reset, then `req=001`, color0=3'b001, dur0=3, half0=0. Required response:
  - `grant=001` one cycle later.
  - r=0, g=b=1 for exactly 12 cycles.
  - `done=001`, then r=g=b=1.
- `req=110` in the same IDLE cycle. Required response: grant=010 first. After done=010, grant=100 follows 2 cycles later (req[2] held).
- TICK_DIV=4, color=3'b111, dur=4, half=1. Required response: LED on/off toggles every 4 cycles (on, off, on, off) across 16 cycles, then done. With dur=0, the play lasts exactly 4 cycles.
- Assert `rst` low mid-PLAY. Required response:
  - r=g=b=1 and busy=0 immediately, asynchronously.
  - No `done` pulse.
  - After release, a new req is granted normally.
- Preemption, with req2 playing dur=10 and req[0] asserted at tick 3:
  - With `RGB_SCHED_PREEMPT_EN`: grant=001 the next cycle and no done[2].
  - Without the macro: req2 completes all 40 cycles and done=100, then grant=001.
